systolic_feeder: RTL and testbench

Operand transmitter for the 2x2 weight/data systolic array. It buffers matrix A (data rows) and matrix B (weight columns) written by the host or controller. On a start pulse it streams both matrices into the array's data and weight lanes with a per-lane diagonal skew, and drives systolic_en for the whole pass. It signals done when the array has received every operand plus the propagation flush.

---
 rtl/systolic_feeder.sv | 124 ++++++++++++
 tb/tb_systolic_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Purpose : buffers A (data rows) and B (weight columns) and streams them diagonally skewed into a 2D systolic array.
// Latency : lanes carry step-0 operands the cycle after start; STREAM lasts K_DEPTH+2*ARRAY_SIZE-2 cycles, then one DONE cycle.
// Backpr. : no downstream backpressure; host writes accepted only while wr_ready (IDLE), start outside IDLE is ignored.
//
// Ports: clk/rst (async active-low); wr_en/wr_sel/wr_addr/wr_data/wr_ready host write port
// (A: row*K_DEPTH+k, B: col*K_DEPTH+k); start single-cycle pass request; data_out/weight_out
// skewed lanes (lane i at [i*DATAW +: DATAW]); systolic_en array enable; busy; done end-of-pass pulse.
module systolic_feeder #(
    parameter int DATAW      = 16,
    parameter int ARRAY_SIZE = 2,
    parameter int K_DEPTH    = 4,
    parameter int AW         = $clog2(ARRAY_SIZE*K_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        wr_sel,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DATAW-1:0]            wr_data,
    output logic                        wr_ready,
    input  logic                        start,
    output logic [ARRAY_SIZE*DATAW-1:0] data_out,
    output logic [ARRAY_SIZE*DATAW-1:0] weight_out,
    output logic                        systolic_en,
    output logic                        busy,
    output logic                        done
);

    localparam int DEPTH = ARRAY_SIZE*K_DEPTH;
    localparam int LAST  = K_DEPTH + 2*ARRAY_SIZE - 3;
    localparam int SW    = $clog2(LAST+1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state;
    logic [SW-1:0]     step;
    logic [DATAW-1:0]  a_buf [DEPTH];
    logic [DATAW-1:0]  b_buf [DEPTH];

    logic                        wr_acc;
    logic [SW-1:0]               nxt_step;
    logic [AW-1:0]               a_idx;
    logic [AW-1:0]               b_idx;
    logic [ARRAY_SIZE*DATAW-1:0] data_nxt;
    logic [ARRAY_SIZE*DATAW-1:0] weight_nxt;

    // Out-of-range addresses are compared one bit wider so a non-power-of-two depth is caught.
    assign wr_acc = wr_en && (state == IDLE) && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

    // Lane values for the step the outputs will show next cycle. A write landing in the
    // same cycle as start is forwarded so the pass sees the new operand.
    always_comb begin
        nxt_step   = (state == IDLE) ? '0 : step + 1'b1;
        a_idx      = '0;
        b_idx      = '0;
        data_nxt   = '0;
        weight_nxt = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (int'(nxt_step) >= i && int'(nxt_step) - i < K_DEPTH) begin
                a_idx = AW'(i*K_DEPTH + int'(nxt_step) - i);
                b_idx = AW'(i*K_DEPTH + int'(nxt_step) - i);
                data_nxt[i*DATAW +: DATAW]   = (wr_acc && !wr_sel && wr_addr == a_idx) ? wr_data : a_buf[a_idx];
                weight_nxt[i*DATAW +: DATAW] = (wr_acc &&  wr_sel && wr_addr == b_idx) ? wr_data : b_buf[b_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            step        <= '0;
            data_out    <= '0;
            weight_out  <= '0;
            systolic_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_ready    <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                a_buf[i] <= '0;
                b_buf[i] <= '0;
            end
        end else begin
            if (wr_acc) begin
                if (wr_sel) b_buf[wr_addr] <= wr_data;
                else        a_buf[wr_addr] <= wr_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= STREAM;
                        step        <= nxt_step;
                        data_out    <= data_nxt;
                        weight_out  <= weight_nxt;
                        systolic_en <= 1'b1;
                        busy        <= 1'b1;
                        wr_ready    <= 1'b0;
                    end
                end
                STREAM: begin
                    if (step == SW'(LAST)) begin
                        // Dropping the enable here also clears the array's own enable counter.
                        state       <= DONE;
                        data_out    <= '0;
                        weight_out  <= '0;
                        systolic_en <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        step       <= nxt_step;
                        data_out   <= data_nxt;
                        weight_out <= weight_nxt;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

    localparam int DW   = 16;
    localparam int N    = 2;
    localparam int KD   = 4;
    localparam int AWL  = 3;
    localparam int PASS = KD + 2*N - 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_en = 1'b0;
    logic            wr_sel = 1'b0;
    logic [AWL-1:0]  wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            wr_ready;
    logic            start = 1'b0;
    logic [N*DW-1:0] data_out;
    logic [N*DW-1:0] weight_out;
    logic            systolic_en;
    logic            busy;
    logic            done;

    systolic_feeder #(.DATAW(DW), .ARRAY_SIZE(N), .K_DEPTH(KD)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready), .start(start), .data_out(data_out),
        .weight_out(weight_out), .systolic_en(systolic_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] d;
        logic [N*DW-1:0] w;
        bit              is_done;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [DW-1:0] mA [N][KD];   // mA[row][k]
    logic [DW-1:0] mB [N][KD];   // mB[col][k]

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < KD; k++) begin
                mA[r][k] = '0;
                mB[r][k] = '0;
            end
    endtask

    // Reference: lane i at step t carries operand index t-i when that index is in range.
    task automatic push_model();
        exp_t e;
        for (int t = 0; t < PASS; t++) begin
            e.d = '0; e.w = '0; e.is_done = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < KD) begin
                    e.d[i*DW +: DW] = mA[i][t-i];
                    e.w[i*DW +: DW] = mB[i][t-i];
                end
            end
            exp_q.push_back(e);
        end
        e.d = '0; e.w = '0; e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Drives a write for the next edge; the model is updated only when the bench knows it is IDLE.
    task automatic setup_write(input bit sel, input int addr, input logic [DW-1:0] val);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr[AWL-1:0]; wr_data = val;
        if (sel) mB[addr/KD][addr%KD] = val;
        else     mA[addr/KD][addr%KD] = val;
    endtask

    task automatic wr(input bit sel, input int addr, input logic [DW-1:0] val);
        setup_write(sel, addr, val);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_pass(input bit disturb, input bit use_model);
        if (use_model) push_model();
        start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        for (int s = 0; s < PASS; s++) begin
            chk("busy_stream", busy, 1);
            chk("wr_ready_stream", wr_ready, 0);
            if (disturb) begin
                start   = (s == 2) || ($urandom_range(0, 2) == 0);
                wr_en   = 1'b1;
                wr_sel  = (s == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                wr_addr = (s == 0) ? '0 : AWL'($urandom_range(0, 7));
                wr_data = (s == 0) ? 16'd99 : 16'($urandom);
            end
            tick();
            start = 1'b0; wr_en = 1'b0;
        end
        chk("busy_done_cycle", busy, 1);
        chk("wr_ready_done_cycle", wr_ready, 0);
        if (disturb) start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_idle", busy, 0);
        chk("wr_ready_idle", wr_ready, 1);
        chk("done_idle", done, 0);
    endtask

    // Monitor: every enabled or done cycle must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && (systolic_en || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: en=%0b done=%0b data=%0h weight=%0h", systolic_en, done, data_out, weight_out);
            end else begin
                e = exp_q.pop_front();
                if (done !== e.is_done || systolic_en !== !e.is_done || data_out !== e.d || weight_out !== e.w) begin
                    failures++;
                    $display("FAIL lane_cycle: en=%0b done=%0b data=%0h weight=%0h expected en=%0b done=%0b data=%0h weight=%0h",
                             systolic_en, done, data_out, weight_out, !e.is_done, e.is_done, e.d, e.w);
                end
            end
        end
    end

    initial begin
        int d0 [PASS];
        int d1 [PASS];
        int w0 [PASS];
        int w1 [PASS];
        exp_t e;
        d0 = '{1, 2, 3, 4, 0, 0};
        d1 = '{0, 5, 6, 7, 8, 0};
        w0 = '{1, 1, 1, 1, 0, 0};
        w1 = '{0, 2, 0, 1, 0, 0};
        clear_model();

        // Reset values
        #2;
        chk("rst_data_out", data_out, 0);
        chk("rst_weight_out", weight_out, 0);
        chk("rst_systolic_en", systolic_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        chk("wr_ready_after_reset", wr_ready, 1);

        // Cleared buffers stream zeros
        do_pass(0, 1);

        // Directed load and stream with literal expectations
        for (int k = 0; k < KD; k++) begin
            wr(0, k, 16'(k + 1));
            wr(0, KD + k, 16'(k + 5));
            wr(1, k, 16'd1);
        end
        wr(1, KD + 0, 16'd2);
        wr(1, KD + 1, 16'd0);
        wr(1, KD + 2, 16'd1);
        wr(1, KD + 3, 16'd0);
        for (int t = 0; t < PASS; t++) begin
            e.d = {16'(d1[t]), 16'(d0[t])};
            e.w = {16'(w1[t]), 16'(w0[t])};
            e.is_done = 1'b0;
            exp_q.push_back(e);
        end
        e.d = '0; e.w = '0; e.is_done = 1'b1;
        exp_q.push_back(e);
        do_pass(0, 0);

        // Writes and starts during the pass are dropped; next pass still sees A[0][0]=1
        do_pass(1, 1);
        do_pass(0, 1);

        // Same-cycle write and start: the pass uses the new value
        setup_write(0, 0, 16'd7);
        do_pass(0, 1);

        // Asynchronous reset at step 3 aborts the pass with no done pulse
        push_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        chk("abort_data_out", data_out, 0);
        chk("abort_weight_out", weight_out, 0);
        chk("abort_systolic_en", systolic_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        clear_model();
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        chk("wr_ready_after_abort", wr_ready, 1);
        chk("busy_after_abort", busy, 0);
        do_pass(0, 1);

        // Randomized loads, same-cycle writes and disturbed passes
        for (int p = 0; p < 8; p++) begin
            int nw;
            nw = $urandom_range(0, 5);
            for (int n = 0; n < nw; n++)
                wr(1'($urandom_range(0, 1)), $urandom_range(0, N*KD-1), 16'($urandom));
            if ($urandom_range(0, 1) == 1)
                setup_write(1'($urandom_range(0, 1)), $urandom_range(0, N*KD-1), 16'($urandom));
            do_pass(1'($urandom_range(0, 1)), 1);
        end

        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
